// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and the issue stage.
// Fetch (master) pushes up to three slots per cycle; issue reads the oldest three.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic [2:0]       in_valid;
  logic [31:0]      in_pc0;
  logic [31:0]      in_pc1;
  logic [31:0]      in_pc2;
  logic [31:0]      in_instr0;
  logic [31:0]      in_instr1;
  logic [31:0]      in_instr2;
  logic             in_ready;
  logic [2:0]       accepted;
  logic [2:0]       out_valid;
  logic [31:0]      out_pc0;
  logic [31:0]      out_pc1;
  logic [31:0]      out_pc2;
  logic [31:0]      out_instr0;
  logic [31:0]      out_instr1;
  logic [31:0]      out_instr2;
  logic [1:0]       deq_cnt;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_pc0, in_pc1, in_pc2,
           in_instr0, in_instr1, in_instr2, deq_cnt,
    input  in_ready, accepted, out_valid, out_pc0, out_pc1, out_pc2,
           out_instr0, out_instr1, out_instr2, count
  );

  modport slave (
    input  flush, in_valid, in_pc0, in_pc1, in_pc2,
           in_instr0, in_instr1, in_instr2, deq_cnt,
    output in_ready, accepted, out_valid, out_pc0, out_pc1, out_pc2,
           out_instr0, out_instr1, out_instr2, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue: up to three in-order enqueues and up to three dequeues per cycle.
// Entry storage is not reset; only head, tail and occupancy are.
module fetch_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.slave  fq
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SLOTS = 3;

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [2:0]       in_mask_c;
  logic [1:0]       n_in_c;
  logic [1:0]       n_enq_c;
  logic [1:0]       n_out_c;
  logic             in_ready_c;
  logic             enq_c;

  logic [31:0]      in_pc_c    [SLOTS];
  logic [31:0]      in_instr_c [SLOTS];
  logic [2:0]       out_valid_c;
  logic [31:0]      out_pc_c    [SLOTS];
  logic [31:0]      out_instr_c [SLOTS];

  assign in_pc_c[0]    = fq.in_pc0;
  assign in_pc_c[1]    = fq.in_pc1;
  assign in_pc_c[2]    = fq.in_pc2;
  assign in_instr_c[0] = fq.in_instr0;
  assign in_instr_c[1] = fq.in_instr1;
  assign in_instr_c[2] = fq.in_instr2;

  // Only the leading run of valid slots is taken; anything past the first gap is dropped.
  always_comb begin
    in_mask_c = 3'b000;
    n_in_c    = 2'd0;
    if (fq.in_valid[0]) begin
      in_mask_c = 3'b001;
      n_in_c    = 2'd1;
      if (fq.in_valid[1]) begin
        in_mask_c = 3'b011;
        n_in_c    = 2'd2;
        if (fq.in_valid[2]) begin
          in_mask_c = 3'b111;
          n_in_c    = 2'd3;
        end
      end
    end
  end

  // Ready looks at registered occupancy only, so a full 3-slot burst always fits.
  assign in_ready_c = (count_q <= CNT_W'(DEPTH - SLOTS));
  assign enq_c      = in_ready_c && !fq.flush && rst_n;
  assign n_enq_c    = enq_c ? n_in_c : 2'd0;
  assign n_out_c    = (count_q < CNT_W'(fq.deq_cnt)) ? count_q[1:0] : fq.deq_cnt;

  always_comb begin
    head_d  = head_q + PTR_W'(n_out_c);
    tail_d  = tail_q + PTR_W'(n_enq_c);
    count_d = count_q + CNT_W'(n_enq_c) - CNT_W'(n_out_c);
    if (fq.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Slot k lands at tail+k; pointer width gives the modulo-DEPTH wrap for free.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(SLOTS); k++) begin
      if (enq_c && in_mask_c[k]) begin
        pc_mem[tail_q + PTR_W'(k)]    <= in_pc_c[k];
        instr_mem[tail_q + PTR_W'(k)] <= in_instr_c[k];
      end
    end
  end

  // Issue view of the oldest three entries; invalid slots read as zero.
  always_comb begin
    out_valid_c = 3'b000;
    for (int k = 0; k < int'(SLOTS); k++) begin
      out_valid_c[k] = (count_q > CNT_W'(k));
      out_pc_c[k]    = out_valid_c[k] ? pc_mem[head_q + PTR_W'(k)]    : 32'd0;
      out_instr_c[k] = out_valid_c[k] ? instr_mem[head_q + PTR_W'(k)] : 32'd0;
    end
  end

  assign fq.in_ready   = in_ready_c;
  assign fq.accepted   = enq_c ? in_mask_c : 3'b000;
  assign fq.out_valid  = out_valid_c;
  assign fq.out_pc0    = out_pc_c[0];
  assign fq.out_pc1    = out_pc_c[1];
  assign fq.out_pc2    = out_pc_c[2];
  assign fq.out_instr0 = out_instr_c[0];
  assign fq.out_instr1 = out_instr_c[1];
  assign fq.out_instr2 = out_instr_c[2];
  assign fq.count      = count_q;

  count_within_depth: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) fq();
  fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .fq(fq));

  ent_t        mq[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] next_pc = 32'd0;

  function automatic int contig(input logic [2:0] v);
    if (!v[0]) return 0;
    if (!v[1]) return 1;
    if (!v[2]) return 2;
    return 3;
  endfunction

  function automatic logic exp_ready();
    return (int'(DEPTH) - mq.size()) >= 3;
  endfunction

  function automatic logic [2:0] exp_accepted();
    if (fq.flush || !exp_ready()) return 3'b000;
    return 3'((1 << contig(fq.in_valid)) - 1);
  endfunction

  function automatic logic [31:0] dut_pc(input int k);
    case (k)
      0:       return fq.out_pc0;
      1:       return fq.out_pc1;
      default: return fq.out_pc2;
    endcase
  endfunction

  function automatic logic [31:0] dut_instr(input int k);
    case (k)
      0:       return fq.out_instr0;
      1:       return fq.out_instr1;
      default: return fq.out_instr2;
    endcase
  endfunction

  task automatic apply(input logic fl, input logic [2:0] v, input logic [1:0] d);
    fq.flush     = fl;
    fq.in_valid  = v;
    fq.deq_cnt   = d;
    fq.in_pc0    = next_pc;
    fq.in_pc1    = next_pc + 32'd4;
    fq.in_pc2    = next_pc + 32'd8;
    fq.in_instr0 = $urandom;
    fq.in_instr1 = $urandom;
    fq.in_instr2 = $urandom;
    #1;
  endtask

  // Advance one clock, updating the model from the inputs presented before the edge.
  task automatic tick();
    ent_t slot[3];
    int   n_in;
    int   n_out;
    logic rdy;
    slot[0] = '{pc: fq.in_pc0, instr: fq.in_instr0};
    slot[1] = '{pc: fq.in_pc1, instr: fq.in_instr1};
    slot[2] = '{pc: fq.in_pc2, instr: fq.in_instr2};
    rdy  = exp_ready();
    n_in = contig(fq.in_valid);
    if (fq.flush) begin
      mq.delete();
    end else begin
      n_out = (int'(fq.deq_cnt) < mq.size()) ? int'(fq.deq_cnt) : mq.size();
      repeat (n_out) void'(mq.pop_front());
      if (rdy) begin
        for (int k = 0; k < n_in; k++) mq.push_back(slot[k]);
        next_pc = next_pc + 32'(4 * n_in);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b0, 3'b111, 2'd0);
    n_checks++; if (fq.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", fq.in_ready); else n_pass++;
    n_checks++; if (fq.accepted !== 3'b000) $display("FAIL rst_accepted: got %b expected 000", fq.accepted); else n_pass++;
    n_checks++; if (fq.out_valid !== 3'b000) $display("FAIL rst_out_valid: got %b expected 000", fq.out_valid); else n_pass++;
    n_checks++; if (fq.out_pc0 !== 32'd0) $display("FAIL rst_out_pc0: got %h expected 0", fq.out_pc0); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (fq.count !== CNT_W'(0)) $display("FAIL rst_count: got %0d expected 0", fq.count); else n_pass++;
    @(negedge clk);
    fq.in_valid = 3'b000;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
    next_pc = 32'd0;
  endtask

  task automatic test_basic();
    apply(1'b0, 3'b111, 2'd0);
    n_checks++; if (fq.accepted !== 3'b111) $display("FAIL basic_accepted: got %b expected 111", fq.accepted); else n_pass++;
    tick();
    n_checks++; if (fq.out_valid !== 3'b111) $display("FAIL basic_out_valid: got %b expected 111", fq.out_valid); else n_pass++;
    n_checks++; if (fq.out_pc0 !== 32'h0) $display("FAIL basic_pc0: got %h expected 0", fq.out_pc0); else n_pass++;
    n_checks++; if (fq.out_pc1 !== 32'h4) $display("FAIL basic_pc1: got %h expected 4", fq.out_pc1); else n_pass++;
    n_checks++; if (fq.out_pc2 !== 32'h8) $display("FAIL basic_pc2: got %h expected 8", fq.out_pc2); else n_pass++;
    n_checks++; if (fq.count !== CNT_W'(3)) $display("FAIL basic_count: got %0d expected 3", fq.count); else n_pass++;
    n_checks++; if (fq.out_instr2 !== mq[2].instr) $display("FAIL basic_instr2: got %h expected %h", fq.out_instr2, mq[2].instr); else n_pass++;
  endtask

  task automatic test_gap();
    apply(1'b0, 3'b101, 2'd0);
    n_checks++; if (fq.accepted !== 3'b001) $display("FAIL gap_accepted: got %b expected 001", fq.accepted); else n_pass++;
    tick();
    n_checks++; if (fq.count !== CNT_W'(4)) $display("FAIL gap_count: got %0d expected 4", fq.count); else n_pass++;
    n_checks++; if (fq.count !== CNT_W'(mq.size())) $display("FAIL gap_model_count: got %0d expected %0d", fq.count, mq.size()); else n_pass++;
  endtask

  task automatic test_full();
    apply(1'b1, 3'b000, 2'd0);
    tick();
    n_checks++; if (fq.count !== CNT_W'(0)) $display("FAIL full_flush_count: got %0d expected 0", fq.count); else n_pass++;
    apply(1'b0, 3'b111, 2'd0);
    tick();
    apply(1'b0, 3'b111, 2'd0);
    tick();
    n_checks++; if (fq.count !== CNT_W'(6)) $display("FAIL full_count6: got %0d expected 6", fq.count); else n_pass++;
    n_checks++; if (fq.in_ready !== 1'b0) $display("FAIL full_ready6: got %b expected 0", fq.in_ready); else n_pass++;
    apply(1'b0, 3'b111, 2'd0);
    n_checks++; if (fq.accepted !== 3'b000) $display("FAIL full_blocked_acc: got %b expected 000", fq.accepted); else n_pass++;
    tick();
    n_checks++; if (fq.count !== CNT_W'(6)) $display("FAIL full_blocked_count: got %0d expected 6", fq.count); else n_pass++;
    apply(1'b0, 3'b000, 2'd1);
    tick();
    n_checks++; if (fq.count !== CNT_W'(5)) $display("FAIL full_count5: got %0d expected 5", fq.count); else n_pass++;
    n_checks++; if (fq.in_ready !== 1'b1) $display("FAIL full_ready5: got %b expected 1", fq.in_ready); else n_pass++;
    apply(1'b0, 3'b111, 2'd0);
    tick();
    n_checks++; if (fq.count !== CNT_W'(DEPTH)) $display("FAIL full_count_depth: got %0d expected %0d", fq.count, DEPTH); else n_pass++;
    n_checks++; if (fq.out_pc0 !== mq[0].pc) $display("FAIL full_pc0: got %h expected %h", fq.out_pc0, mq[0].pc); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] base;
    apply(1'b1, 3'b000, 2'd0);
    tick();
    apply(1'b0, 3'b111, 2'd0);
    tick();
    apply(1'b0, 3'b111, 2'd3);
    tick();
    apply(1'b0, 3'b000, 2'd3);
    tick();
    apply(1'b0, 3'b011, 2'd0);
    tick();
    n_checks++; if (fq.count !== CNT_W'(2)) $display("FAIL wrap_pre_count: got %0d expected 2", fq.count); else n_pass++;
    n_checks++; if (fq.out_valid !== 3'b011) $display("FAIL wrap_pre_valid: got %b expected 011", fq.out_valid); else n_pass++;
    n_checks++; if (fq.out_pc2 !== 32'd0) $display("FAIL wrap_pre_pc2: got %h expected 0", fq.out_pc2); else n_pass++;
    n_checks++; if (fq.out_pc1 !== mq[1].pc) $display("FAIL wrap_pre_pc1: got %h expected %h", fq.out_pc1, mq[1].pc); else n_pass++;
    base = next_pc;
    apply(1'b0, 3'b111, 2'd2);
    tick();
    n_checks++; if (fq.count !== CNT_W'(3)) $display("FAIL wrap_count: got %0d expected 3", fq.count); else n_pass++;
    n_checks++; if (fq.out_pc0 !== base) $display("FAIL wrap_pc0: got %h expected %h", fq.out_pc0, base); else n_pass++;
    n_checks++; if (fq.out_pc1 !== base + 32'd4) $display("FAIL wrap_pc1: got %h expected %h", fq.out_pc1, base + 32'd4); else n_pass++;
    n_checks++; if (fq.out_pc2 !== base + 32'd8) $display("FAIL wrap_pc2: got %h expected %h", fq.out_pc2, base + 32'd8); else n_pass++;
    n_checks++; if (fq.out_instr0 !== mq[0].instr) $display("FAIL wrap_instr0: got %h expected %h", fq.out_instr0, mq[0].instr); else n_pass++;
  endtask

  task automatic test_overdeq_flush();
    apply(1'b0, 3'b000, 2'd2);
    tick();
    n_checks++; if (fq.count !== CNT_W'(1)) $display("FAIL odq_count1: got %0d expected 1", fq.count); else n_pass++;
    apply(1'b0, 3'b000, 2'd3);
    tick();
    n_checks++; if (fq.count !== CNT_W'(0)) $display("FAIL odq_count0: got %0d expected 0", fq.count); else n_pass++;
    n_checks++; if (fq.out_valid !== 3'b000) $display("FAIL odq_valid: got %b expected 000", fq.out_valid); else n_pass++;
    apply(1'b0, 3'b111, 2'd0);
    tick();
    apply(1'b1, 3'b111, 2'd1);
    n_checks++; if (fq.accepted !== 3'b000) $display("FAIL flush_accepted: got %b expected 000", fq.accepted); else n_pass++;
    tick();
    n_checks++; if (fq.count !== CNT_W'(0)) $display("FAIL flush_count: got %0d expected 0", fq.count); else n_pass++;
    n_checks++; if (fq.out_valid !== 3'b000) $display("FAIL flush_valid: got %b expected 000", fq.out_valid); else n_pass++;
  endtask

  task automatic test_async_reset();
    apply(1'b0, 3'b111, 2'd0);
    tick();
    apply(1'b0, 3'b011, 2'd0);
    tick();
    n_checks++; if (fq.count !== CNT_W'(5)) $display("FAIL arst_pre_count: got %0d expected 5", fq.count); else n_pass++;
    fq.in_valid = 3'b111;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (fq.out_valid !== 3'b000) $display("FAIL arst_valid: got %b expected 000", fq.out_valid); else n_pass++;
    n_checks++; if (fq.in_ready !== 1'b1) $display("FAIL arst_ready: got %b expected 1", fq.in_ready); else n_pass++;
    n_checks++; if (fq.count !== CNT_W'(0)) $display("FAIL arst_count: got %0d expected 0", fq.count); else n_pass++;
    n_checks++; if (fq.accepted !== 3'b000) $display("FAIL arst_accepted: got %b expected 000", fq.accepted); else n_pass++;
    mq.delete();
    @(negedge clk);
    fq.in_valid = 3'b000;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(1'b0, 3'b111, 2'd0);
    tick();
    n_checks++; if (fq.count !== CNT_W'(3)) $display("FAIL arst_resume_count: got %0d expected 3", fq.count); else n_pass++;
    n_checks++; if (fq.out_pc0 !== mq[0].pc) $display("FAIL arst_resume_pc0: got %h expected %h", fq.out_pc0, mq[0].pc); else n_pass++;
  endtask

  task automatic test_random();
    logic        fl;
    logic [2:0]  v;
    logic [1:0]  d;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    for (int i = 0; i < 400; i++) begin
      fl = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111;
      d  = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom);
      apply(fl, v, d);
      n_checks++; if (fq.in_ready !== exp_ready()) $display("FAIL rnd_ready[%0d]: got %b expected %b", i, fq.in_ready, exp_ready()); else n_pass++;
      n_checks++; if (fq.accepted !== exp_accepted()) $display("FAIL rnd_accepted[%0d]: got %b expected %b", i, fq.accepted, exp_accepted()); else n_pass++;
      tick();
      n_checks++; if (fq.count !== CNT_W'(mq.size())) $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, fq.count, mq.size()); else n_pass++;
      for (int k = 0; k < 3; k++) begin
        ev  = (k < mq.size());
        epc = ev ? mq[k].pc : 32'd0;
        ein = ev ? mq[k].instr : 32'd0;
        n_checks++; if (fq.out_valid[k] !== ev) $display("FAIL rnd_valid%0d[%0d]: got %b expected %b", k, i, fq.out_valid[k], ev); else n_pass++;
        n_checks++; if (dut_pc(k) !== epc) $display("FAIL rnd_pc%0d[%0d]: got %h expected %h", k, i, dut_pc(k), epc); else n_pass++;
        n_checks++; if (dut_instr(k) !== ein) $display("FAIL rnd_instr%0d[%0d]: got %h expected %h", k, i, dut_instr(k), ein); else n_pass++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    fq.flush = 1'b0;
    fq.in_valid = 3'b000;
    fq.deq_cnt = 2'd0;
    fq.in_pc0 = '0;
    fq.in_pc1 = '0;
    fq.in_pc2 = '0;
    fq.in_instr0 = '0;
    fq.in_instr1 = '0;
    fq.in_instr2 = '0;
    test_reset();
    test_basic();
    test_gap();
    test_full();
    test_wrap();
    test_overdeq_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
